sum_accumulator: RTL and testbench

Downstream consumer of the `adder` stage. It collects a programmed number of adder results (`D_WIDTH+1`-bit sums) over a valid/ready stream, accumulates them into a wide unsigned register, and presents the total on a valid/ready output. It sits between the adder's registered `c` output and any block that needs block-wise totals of the adder results.

---
 rtl/sum_accumulator_pkg.sv | 22 ++
 rtl/sum_accumulator.sv | 164 ++++++++++++++++
 tb/tb_sum_accumulator.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/sum_accumulator_pkg.sv
// -----------------------------------------------------------------------------
// sum_accumulator_pkg
// Shared types and default widths for the sum_accumulator block.
//   state_e         : FSM encoding (IDLE / ACCUM / DONE)
//   DEF_D_WIDTH     : default adder operand width
//   DEF_CNT_WIDTH   : default beat-count field width
//   DEF_ACC_WIDTH   : default accumulator width; wide enough that a full run
//                     of maximum-value beats can never overflow
// -----------------------------------------------------------------------------
package sum_accumulator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int DEF_D_WIDTH   = 32;
  localparam int DEF_CNT_WIDTH = 8;
  localparam int DEF_ACC_WIDTH = DEF_D_WIDTH + 1 + DEF_CNT_WIDTH;

endpackage : sum_accumulator_pkg

// File: rtl/sum_accumulator.sv
// -----------------------------------------------------------------------------
// sum_accumulator
// Collects a programmed number of adder results over a valid/ready stream,
// sums them into a wide unsigned accumulator and offers the total on a
// valid/ready output.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   start a run (honoured only in IDLE)
//   count      in   [CNT_WIDTH]  beats in the run, sampled with start
//   in_valid   in   input beat valid
//   in_data    in   [D_WIDTH+1]  unsigned adder result
//   in_ready   out  ready for an input beat (ACCUM)
//   out_valid  out  total valid (DONE)
//   out_data   out  [ACC_WIDTH]  accumulated total
//   out_ready  in   downstream accepts the total
//   busy       out  run in progress (ACCUM or DONE)
//
// Build option:
//   SUM_ACCUMULATOR_SATURATE_EN  defined   -> accumulator clamps at all-ones
//                                undefined -> accumulator wraps
// -----------------------------------------------------------------------------
module sum_accumulator
  import sum_accumulator_pkg::*;
#(
  parameter int D_WIDTH   = DEF_D_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH,
  parameter int ACC_WIDTH = D_WIDTH + 1 + CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] count,
  input  logic                 in_valid,
  input  logic [D_WIDTH:0]     in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [ACC_WIDTH-1:0] out_data,
  input  logic                 out_ready,
  output logic                 busy
);

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   remaining_q, remaining_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic                   accept_s;

  // Accumulator update: zero-extend the beat, then wrap or clamp.
  function automatic logic [ACC_WIDTH-1:0] acc_add(
    input logic [ACC_WIDTH-1:0] acc,
    input logic [D_WIDTH:0]     beat
  );
`ifdef SUM_ACCUMULATOR_SATURATE_EN
    logic [ACC_WIDTH:0] sum;
    sum = {1'b0, acc} + (ACC_WIDTH+1)'(beat);
    // Carry out means the true sum exceeds the register range.
    if (sum[ACC_WIDTH]) begin
      return {ACC_WIDTH{1'b1}};
    end else begin
      return sum[ACC_WIDTH-1:0];
    end
`else
    return acc + ACC_WIDTH'(beat);
`endif
  endfunction

  assign accept_s = in_valid && in_ready;

  // State, beat counter and accumulator registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      acc_q       <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      acc_q       <= acc_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    acc_d       = acc_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d = '0;
          if (count != '0) begin
            remaining_d = count;
            state_d     = ST_ACCUM;
          end else begin
            // Empty run: report a zero total straight away.
            remaining_d = '0;
            state_d     = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (accept_s) begin
          acc_d       = acc_add(acc_q, in_data);
          remaining_d = remaining_q - CNT_WIDTH'(1);
          if (remaining_q == CNT_WIDTH'(1)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ACCUM;
          end
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_DONE: begin
        // start is deliberately not looked at here, even on the handshake cycle.
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        remaining_d = '0;
        acc_d       = '0;
      end
    endcase
  end

  // Output decode from registered state only.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
      end
      ST_ACCUM: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        busy      = 1'b1;
      end
      ST_DONE: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
      end
    endcase
  end

  assign out_data = acc_q;

endmodule : sum_accumulator

// File: tb/tb_sum_accumulator.sv
// -----------------------------------------------------------------------------
// tb_sum_accumulator
// Directed bench for sum_accumulator. A default-width instance and a narrow
// (ACC_WIDTH = D_WIDTH+1) instance share all inputs; the narrow one exercises
// accumulator overflow.
// -----------------------------------------------------------------------------
module tb_sum_accumulator;

  localparam int DW  = 32;
  localparam int CW  = 8;
  localparam int AW  = DW + 1 + CW;
  localparam int AWN = DW + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] count;
  logic          in_valid;
  logic [DW:0]   in_data;
  logic          out_ready;

  logic          in_ready,  out_valid,  busy;
  logic [AW-1:0] out_data;
  logic          n_in_ready, n_out_valid, n_busy;
  logic [AWN-1:0] n_out_data;

  int pass_cnt  = 0;
  int check_cnt = 0;

  always #5 clk = ~clk;

  sum_accumulator #(.D_WIDTH(DW), .CNT_WIDTH(CW), .ACC_WIDTH(AW)) u_dut (
    .clk(clk), .rst(rst), .start(start), .count(count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy)
  );

  sum_accumulator #(.D_WIDTH(DW), .CNT_WIDTH(CW), .ACC_WIDTH(AWN)) u_narrow (
    .clk(clk), .rst(rst), .start(start), .count(count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(n_in_ready),
    .out_valid(n_out_valid), .out_data(n_out_data), .out_ready(out_ready),
    .busy(n_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one clock; inputs and samples sit 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; count = '0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b1;

    // Reset state
    step(); step();
    chk("rst_in_ready",  64'(in_ready),  64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    rst = 1'b0;
    step();

    // Basic run: 5 + 15 + 40
    start = 1'b1; count = 8'd3;
    step();
    start = 1'b0;
    chk("basic_accum_ready", 64'(in_ready), 64'd1);
    chk("basic_busy",        64'(busy),     64'd1);
    in_valid = 1'b1; in_data = 33'd5;  step();
    in_data = 33'd15; step();
    chk("basic_no_early_valid", 64'(out_valid), 64'd0);
    in_data = 33'd40; step();
    in_valid = 1'b0;
    chk("basic_out_valid", 64'(out_valid), 64'd1);
    chk("basic_out_data",  64'(out_data),  64'd60);
    chk("basic_done_ready", 64'(in_ready), 64'd0);
    step();
    chk("basic_idle_valid", 64'(out_valid), 64'd0);
    chk("basic_idle_busy",  64'(busy),      64'd0);

    // Stalls on both sides: 7 + 9
    out_ready = 1'b0;
    start = 1'b1; count = 8'd2;
    step();
    start = 1'b0;
    in_valid = 1'b1; in_data = 33'd7; step();
    in_valid = 1'b0; in_data = 33'd999;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_in_ready",  64'(in_ready),  64'd1);
      chk("stall_no_valid",  64'(out_valid), 64'd0);
    end
    in_valid = 1'b1; in_data = 33'd9; step();
    in_valid = 1'b0;
    chk("stall_out_valid", 64'(out_valid), 64'd1);
    chk("stall_out_data",  64'(out_data),  64'd16);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("stall_hold_valid", 64'(out_valid), 64'd1);
      chk("stall_hold_data",  64'(out_data),  64'd16);
    end
    out_ready = 1'b1;
    step();
    chk("stall_released", 64'(out_valid), 64'd0);

    // Zero count goes straight to DONE with a zero total
    start = 1'b1; count = 8'd0;
    step();
    start = 1'b0;
    chk("zero_out_valid", 64'(out_valid), 64'd1);
    chk("zero_out_data",  64'(out_data),  64'd0);
    chk("zero_in_ready",  64'(in_ready),  64'd0);
    step();
    chk("zero_idle_valid", 64'(out_valid), 64'd0);
    chk("zero_idle_ready", 64'(in_ready),  64'd0);

    // start held through ACCUM and the DONE handshake is ignored: 3 + 4
    start = 1'b1; count = 8'd2;
    step();
    count = 8'd5;
    in_valid = 1'b1; in_data = 33'd3; step();
    chk("ign_still_accum", 64'(in_ready),  64'd1);
    in_data = 33'd4; step();
    in_valid = 1'b0;
    chk("ign_out_valid", 64'(out_valid), 64'd1);
    chk("ign_out_data",  64'(out_data),  64'd7);
    step();
    chk("ign_no_restart_busy",  64'(busy),     64'd0);
    chk("ign_no_restart_ready", 64'(in_ready), 64'd0);
    start = 1'b0;
    step();
    chk("ign_idle_after", 64'(busy), 64'd0);

    // Mid-run reset discards the partial total
    start = 1'b1; count = 8'd3;
    step();
    start = 1'b0;
    in_valid = 1'b1; in_data = 33'd100; step();
    in_valid = 1'b0;
    chk("mid_partial", 64'(out_data), 64'd100);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 64'(in_ready),  64'd0);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_data",  64'(out_data),  64'd0);
    chk("mid_rst_busy",  64'(busy),      64'd0);
    #2;
    rst = 1'b0;
    step();
    start = 1'b1; count = 8'd1;
    step();
    start = 1'b0;
    in_valid = 1'b1; in_data = 33'd4; step();
    in_valid = 1'b0;
    chk("mid_fresh_valid", 64'(out_valid), 64'd1);
    chk("mid_fresh_data",  64'(out_data),  64'd4);
    step();

    // Overflow on the narrow instance: 2 x (2^32 + 1) = 2^33 + 2
    start = 1'b1; count = 8'd2;
    step();
    start = 1'b0;
    in_valid = 1'b1; in_data = 33'h1_0000_0001; step();
    step();
    in_valid = 1'b0;
    chk("ovf_wide_data", 64'(out_data), 64'h2_0000_0002);
    chk("ovf_narrow_valid", 64'(n_out_valid), 64'd1);
`ifdef SUM_ACCUMULATOR_SATURATE_EN
    chk("ovf_narrow_sat", 64'(n_out_data), 64'h1_FFFF_FFFF);
`else
    // Modulo 2^33 the true sum leaves 2.
    chk("ovf_narrow_wrap", 64'(n_out_data), 64'h2);
`endif
    step();
    chk("ovf_idle", 64'(n_busy), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule : tb_sum_accumulator
